// File: rtl/dcnn_io_pkg.sv
// Shared types and constants for the DCNN I/O sequencer: FSM state encoding,
// default geometry and the helpers that derive beat/row counter sizes.
package dcnn_io_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ROW_FILL = 3'd1,
    S_ROW_HOLD = 3'd2,
    S_DATA     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam int DEF_ROW_W    = 480;
  localparam int DEF_WORD_W   = 16;
  localparam int DEF_IMG_ROWS = 28;

  // Number of input beats needed to assemble one full row.
  function automatic int seg_of(input int row_w, input int word_w);
    return row_w / word_w;
  endfunction

  // Counter width that stays at least one bit even for a single-entry count.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcnn_row_packer.sv
// Row assembly register: a beat counter selects which WORD_W slot of the row
// the next accepted word lands in; beat 0 fills the least significant slot.
module dcnn_row_packer
  import dcnn_io_pkg::*;
#(
  parameter int ROW_W  = DEF_ROW_W,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  output logic [ROW_W-1:0]  row,
  output logic              last_beat
);

  localparam int SEG    = seg_of(ROW_W, WORD_W);
  localparam int BEAT_W = cnt_w(SEG);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SEG - 1);

  logic [BEAT_W-1:0] beat_cnt;

  // Asserted while the slot about to be written completes the row.
  assign last_beat = (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      row      <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
      row      <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < SEG; k++) begin
        if (beat_cnt == BEAT_W'(k)) begin
          row[WORD_W*k +: WORD_W] <= wr_data;
        end
      end
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dcnn_io_sequencer.sv
// Front-end sequencer: packs input words into IMG_ROWS compressed rows handed
// over with row_valid/send, then forwards the remaining words as CNN data.
module dcnn_io_sequencer
  import dcnn_io_pkg::*;
#(
  parameter int ROW_W    = DEF_ROW_W,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int IMG_ROWS = DEF_IMG_ROWS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              interrupt,
  input  logic              stop,
  input  logic              send,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ROW_W-1:0]  row,
  output logic              row_valid,
  output logic [WORD_W-1:0] cnn_data,
  output logic              cnn_valid,
  output logic              load_process,
  output logic              cnn_image,
  output logic              done,
  output logic [2:0]        fsm_state
);

  localparam int ROWS_W = $clog2(IMG_ROWS + 1);
  localparam logic [ROWS_W-1:0] LAST_ROW = ROWS_W'(IMG_ROWS - 1);

  if ((ROW_W % WORD_W) != 0) begin : g_bad_row_w
    $error("dcnn_io_sequencer: ROW_W must be a multiple of WORD_W");
  end
  if (IMG_ROWS < 1) begin : g_bad_img_rows
    $error("dcnn_io_sequencer: IMG_ROWS must be at least 1");
  end

  // Input handshake: a word transfers on a cycle where in_valid & in_ready;
  // in_ready depends only on state and stop, never on in_valid.
  state_t state, state_n;

  logic              row_valid_n, cnn_valid_n, load_n, image_n, done_n;
  logic [WORD_W-1:0] cnn_data_n;
  logic              pk_clear, pk_wr, pk_last;
  logic              row_inc, row_clr;
  logic [ROWS_W-1:0] row_cnt;
  logic              accept;

  assign in_ready  = !stop && ((state == S_ROW_FILL) || (state == S_DATA));
  assign accept    = in_valid && in_ready;
  assign fsm_state = state;

  dcnn_row_packer #(
    .ROW_W  (ROW_W),
    .WORD_W (WORD_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .wr_en     (pk_wr),
    .wr_data   (in_data),
    .row       (row),
    .last_beat (pk_last)
  );

  always_comb begin
    state_n     = state;
    row_valid_n = row_valid;
    cnn_data_n  = cnn_data;
    cnn_valid_n = 1'b0;
    load_n      = load_process;
    image_n     = cnn_image;
    done_n      = done;
    pk_clear    = 1'b0;
    pk_wr       = 1'b0;
    row_inc     = 1'b0;
    row_clr     = 1'b0;

    if (interrupt) begin
      state_n     = S_IDLE;
      row_valid_n = 1'b0;
      cnn_data_n  = '0;
      load_n      = 1'b0;
      image_n     = 1'b0;
      done_n      = 1'b0;
      pk_clear    = 1'b0 | 1'b1;
      row_clr     = 1'b1;
    end else if (!stop) begin
      // stop freezes everything; only the cnn_valid strobe is allowed to drop.
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state_n  = S_ROW_FILL;
            load_n   = 1'b1;
            pk_clear = 1'b1;
            row_clr  = 1'b1;
          end
        end
        S_ROW_FILL: begin
          if (accept) begin
            pk_wr = 1'b1;
            if (pk_last) begin
              state_n     = S_ROW_HOLD;
              row_valid_n = 1'b1;
            end
          end
        end
        S_ROW_HOLD: begin
          if (send) begin
            row_valid_n = 1'b0;
            row_inc     = 1'b1;
            if (row_cnt == LAST_ROW) begin
              state_n = S_DATA;
              image_n = 1'b1;
            end else begin
              state_n = S_ROW_FILL;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            cnn_data_n  = in_data;
            cnn_valid_n = 1'b1;
            if (in_last) begin
              state_n = S_DONE;
              load_n  = 1'b0;
              done_n  = 1'b1;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state_n  = S_ROW_FILL;
            load_n   = 1'b1;
            image_n  = 1'b0;
            done_n   = 1'b0;
            pk_clear = 1'b1;
            row_clr  = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      row_valid    <= 1'b0;
      cnn_data     <= '0;
      cnn_valid    <= 1'b0;
      load_process <= 1'b0;
      cnn_image    <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      row_valid    <= row_valid_n;
      cnn_data     <= cnn_data_n;
      cnn_valid    <= cnn_valid_n;
      load_process <= load_n;
      cnn_image    <= image_n;
      done         <= done_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt <= '0;
    end else if (row_clr) begin
      row_cnt <= '0;
    end else if (row_inc) begin
      row_cnt <= row_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dcnn_io_sequencer.sv
// Bench for dcnn_io_sequencer with a 48-bit row, 16-bit words and two image rows.
module tb_dcnn_io_sequencer;
  import dcnn_io_pkg::*;

  localparam int ROW_W    = 48;
  localparam int WORD_W   = 16;
  localparam int IMG_ROWS = 2;
  localparam int SEG      = ROW_W / WORD_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, interrupt, stop, send, in_valid, in_last;
  logic [WORD_W-1:0] in_data;
  logic              in_ready, row_valid, cnn_valid, load_process, cnn_image, done;
  logic [ROW_W-1:0]  row;
  logic [WORD_W-1:0] cnn_data;
  logic [2:0]        fsm_state;

  int n_tests = 0;
  int n_fail  = 0;

  dcnn_io_sequencer #(
    .ROW_W    (ROW_W),
    .WORD_W   (WORD_W),
    .IMG_ROWS (IMG_ROWS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .interrupt    (interrupt),
    .stop         (stop),
    .send         (send),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .row          (row),
    .row_valid    (row_valid),
    .cnn_data     (cnn_data),
    .cnn_valid    (cnn_valid),
    .load_process (load_process),
    .cnn_image    (cnn_image),
    .done         (done),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; interrupt = 0; stop = 0; send = 0;
    in_valid = 0; in_last = 0; in_data = '0;
  endtask

  task automatic beat(input logic [WORD_W-1:0] d, input logic last);
    in_valid = 1; in_data = d; in_last = last;
    cycle();
    in_valid = 0; in_last = 0;
  endtask

  task automatic pulse_send();
    send = 1; cycle(); send = 0;
  endtask

  task automatic pulse_start();
    start = 1; cycle(); start = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              start, send, in_valid, in_last, stop, intr;
    logic [WORD_W-1:0] in_data;
    logic              exp_ready;
    logic              exp_rv, exp_cv, exp_load, exp_img, exp_done;
    logic [WORD_W-1:0] exp_cdata;
    logic              chk_row;
    logic [ROW_W-1:0]  exp_row;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic sd, input logic v,
                              input logic [WORD_W-1:0] d, input logic l,
                              input logic rdy, input logic rv, input logic cv,
                              input logic ld, input logic img, input logic dn,
                              input logic [WORD_W-1:0] cd, input logic chk,
                              input logic [ROW_W-1:0] r);
    vec_t x;
    x.start = st; x.send = sd; x.in_valid = v; x.in_data = d; x.in_last = l;
    x.stop = 0; x.intr = 0;
    x.exp_ready = rdy; x.exp_rv = rv; x.exp_cv = cv; x.exp_load = ld;
    x.exp_img = img; x.exp_done = dn; x.exp_cdata = cd; x.chk_row = chk; x.exp_row = r;
    return x;
  endfunction

  localparam int NV = 15;
  vec_t vecs [NV];

  // ---------------- scoreboard for the randomized run ----------------
  logic [ROW_W-1:0]  row_q[$];
  logic [WORD_W-1:0] exp_q[$];
  logic              mon_en = 0;
  logic              mon_prev_rv = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (row_valid && !mon_prev_rv) begin
        if (row_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rand_row: unexpected row %0h, none expected", row);
        end else begin
          check("rand_row", row, row_q.pop_front());
        end
      end
      if (cnn_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rand_cnn: unexpected word %0h, none expected", cnn_data);
        end else begin
          check("rand_cnn", cnn_data, exp_q.pop_front());
        end
      end
    end
    mon_prev_rv = row_valid;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [WORD_W-1:0] w[$];
    logic [ROW_W-1:0]  r_exp;
    int                n_words, idx, cyc;
    logic              acc;

    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    cycle();

    check("rst_ready", in_ready, 0);
    check("rst_row", row, 0);
    check("rst_row_valid", row_valid, 0);
    check("rst_cnn_data", cnn_data, 0);
    check("rst_cnn_valid", cnn_valid, 0);
    check("rst_load", load_process, 0);
    check("rst_image", cnn_image, 0);
    check("rst_done", done, 0);

    //        st sd v  data     l  rdy rv cv ld img dn cdata    chk row
    vecs[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 48'h0);
    vecs[1]  = mk(0, 0, 1, 16'h1111, 0, 1, 0, 0, 1, 0, 0, 16'h0000, 0, 48'h0);
    vecs[2]  = mk(0, 0, 1, 16'h2222, 0, 1, 0, 0, 1, 0, 0, 16'h0000, 0, 48'h0);
    vecs[3]  = mk(0, 0, 1, 16'h3333, 0, 1, 1, 0, 1, 0, 0, 16'h0000, 1, 48'h3333_2222_1111);
    vecs[4]  = mk(0, 0, 1, 16'h4444, 0, 0, 1, 0, 1, 0, 0, 16'h0000, 1, 48'h3333_2222_1111);
    vecs[5]  = mk(0, 1, 1, 16'h4444, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 48'h0);
    vecs[6]  = mk(0, 0, 1, 16'h4444, 0, 1, 0, 0, 1, 0, 0, 16'h0000, 0, 48'h0);
    vecs[7]  = mk(0, 0, 1, 16'h5555, 1, 1, 0, 0, 1, 0, 0, 16'h0000, 0, 48'h0);
    vecs[8]  = mk(0, 0, 1, 16'h6666, 0, 1, 1, 0, 1, 0, 0, 16'h0000, 1, 48'h6666_5555_4444);
    vecs[9]  = mk(0, 1, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 0, 16'h0000, 0, 48'h0);
    vecs[10] = mk(0, 0, 1, 16'hAAAA, 0, 1, 0, 1, 1, 1, 0, 16'hAAAA, 0, 48'h0);
    vecs[11] = mk(0, 0, 1, 16'hBBBB, 1, 1, 0, 1, 0, 1, 1, 16'hBBBB, 0, 48'h0);
    vecs[12] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 1, 16'hBBBB, 0, 48'h0);
    vecs[13] = mk(0, 1, 1, 16'hCCCC, 1, 0, 0, 0, 0, 1, 1, 16'hBBBB, 0, 48'h0);
    vecs[14] = mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 16'hBBBB, 0, 48'h0);

    for (int i = 0; i < NV; i++) begin
      start = vecs[i].start; send = vecs[i].send; in_valid = vecs[i].in_valid;
      in_data = vecs[i].in_data; in_last = vecs[i].in_last;
      stop = vecs[i].stop; interrupt = vecs[i].intr;
      #1;
      check($sformatf("vec%0d_ready", i), in_ready, vecs[i].exp_ready);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_row_valid", i), row_valid, vecs[i].exp_rv);
      check($sformatf("vec%0d_cnn_valid", i), cnn_valid, vecs[i].exp_cv);
      check($sformatf("vec%0d_load", i), load_process, vecs[i].exp_load);
      check($sformatf("vec%0d_image", i), cnn_image, vecs[i].exp_img);
      check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
      check($sformatf("vec%0d_cnn_data", i), cnn_data, vecs[i].exp_cdata);
      if (vecs[i].chk_row) check($sformatf("vec%0d_row", i), row, vecs[i].exp_row);
    end
    idle_inputs();

    // stop mid-row: offered word must not be taken, slot position must not move
    beat(16'h1234, 0);
    stop = 1; in_valid = 1; in_data = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stop_ready", in_ready, 0);
      cycle();
      check("stop_row_valid", row_valid, 0);
      check("stop_load", load_process, 1);
    end
    stop = 0; in_valid = 0;
    beat(16'h5678, 0);
    beat(16'h9ABC, 0);
    check("stop_resume_row_valid", row_valid, 1);
    check("stop_resume_row", row, 48'h9ABC_5678_1234);
    stop = 1; send = 1;
    cycle();
    cycle();
    check("stop_send_ignored", row_valid, 1);
    stop = 0;
    cycle();
    send = 0;
    check("send_after_stop", row_valid, 0);

    // interrupt after one beat of row 1, with start in the same cycle
    beat(16'h7777, 0);
    interrupt = 1; start = 1;
    cycle();
    interrupt = 0; start = 0;
    check("intr_state", fsm_state, 3'(S_IDLE));
    check("intr_row", row, 0);
    check("intr_row_valid", row_valid, 0);
    check("intr_load", load_process, 0);
    check("intr_image", cnn_image, 0);
    check("intr_done", done, 0);
    check("intr_cnn_data", cnn_data, 0);
    check("intr_ready", in_ready, 0);
    cycle();
    check("intr_start_not_latched", load_process, 0);
    pulse_start();
    check("restart_load", load_process, 1);
    beat(16'h0102, 0);
    beat(16'h0304, 0);
    beat(16'h0506, 0);
    check("restart_row_valid", row_valid, 1);
    check("restart_row", row, 48'h0506_0304_0102);
    pulse_send();
    beat(16'h0A0A, 0);
    beat(16'h0B0B, 0);
    beat(16'h0C0C, 0);
    pulse_send();
    check("restart_image", cnn_image, 1);
    check("restart_load_data", load_process, 1);

    // asynchronous reset in the data phase
    beat(16'hCCCC, 0);
    check("pre_rst_cnn_valid", cnn_valid, 1);
    check("pre_rst_cnn_data", cnn_data, 16'hCCCC);
    #2 rst = 1;
    #1;
    check("arst_cnn_valid", cnn_valid, 0);
    check("arst_cnn_data", cnn_data, 0);
    check("arst_image", cnn_image, 0);
    check("arst_load", load_process, 0);
    check("arst_ready", in_ready, 0);
    #2 rst = 0;
    cycle();
    check("arst_state", fsm_state, 3'(S_IDLE));

    // full load to DONE, then restart from DONE
    pulse_start();
    for (int r = 0; r < IMG_ROWS; r++) begin
      for (int k = 0; k < SEG; k++) beat(16'(r * 16 + k), 0);
      pulse_send();
    end
    beat(16'hEEEE, 1);
    cycle();
    check("done_done", done, 1);
    check("done_image", cnn_image, 1);
    check("done_load", load_process, 0);
    pulse_start();
    check("redone_done", done, 0);
    check("redone_image", cnn_image, 0);
    check("redone_load", load_process, 1);

    // randomized loads checked against the packing/stream model
    interrupt = 1; cycle(); interrupt = 0;
    mon_en = 1;
    for (int it = 0; it < 20; it++) begin
      w.delete();
      n_words = SEG * IMG_ROWS + $urandom_range(1, 8);
      for (int i = 0; i < n_words; i++) w.push_back(WORD_W'($urandom));
      for (int r = 0; r < IMG_ROWS; r++) begin
        r_exp = '0;
        for (int k = 0; k < SEG; k++) r_exp[WORD_W*k +: WORD_W] = w[r*SEG + k];
        row_q.push_back(r_exp);
      end
      for (int i = SEG * IMG_ROWS; i < n_words; i++) exp_q.push_back(w[i]);

      pulse_start();
      idx = 0;
      cyc = 0;
      while (idx < n_words && cyc < 600) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = w[idx];
        in_last  = (idx == n_words - 1);
        stop     = ($urandom_range(0, 7) == 0);
        send     = ($urandom_range(0, 2) == 0);
        start    = ($urandom_range(0, 15) == 0);
        #1;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) idx++;
        cyc++;
      end
      idle_inputs();
      if (idx < n_words) begin
        n_tests++; n_fail++;
        $display("FAIL rand_timeout: accepted %0d words, required %0d", idx, n_words);
      end
      for (int k = 0; k < 20 && !done; k++) cycle();
      cycle();
      check("rand_done", done, 1);
      check("rand_load_off", load_process, 0);
      check("rand_rows_left", row_q.size(), 0);
      check("rand_words_left", exp_q.size(), 0);
      row_q.delete();
      exp_q.delete();
    end
    mon_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
